updown_count_sequencer: RTL and testbench



---
 rtl/udseq_pkg.sv | 11 +
 rtl/updown_mod_counter.sv | 45 ++++
 rtl/updown_count_sequencer.sv | 105 ++++++++++
 tb/tb_updown_count_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/udseq_pkg.sv
// Shared types and defaults for the up/down count sequencer and its counter.
package udseq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int DEF_MAX_VAL = 10;
   localparam int DEF_CNT_W   = 4;
   localparam int DEF_STEP_W  = 8;
endpackage

// File: rtl/updown_mod_counter.sv
// Mod-(MAX_VAL+1) up/down counter with clamped parallel load.
// wrap_next flags that the next enabled step will wrap around.
module updown_mod_counter
   import udseq_pkg::*;
#(
   parameter int MAX_VAL = DEF_MAX_VAL,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] Count,
   output logic             wrap_next
);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wrap_next = (dir == DIR_UP) ? (count_q == MAX_C) : (count_q == '0);
      count_d   = count_q;
      if (load) begin
         count_d = (load_val > MAX_C) ? MAX_C : load_val;
      end else if (en) begin
         if (wrap_next) begin
            count_d = (dir == DIR_UP) ? '0 : MAX_C;
         end else begin
            count_d = (dir == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign Count = count_q;
endmodule

// File: rtl/updown_count_sequencer.sv
// Command-driven sequencer stepping an embedded mod counter once per clock.
// Define UDSEQ_PRELOAD_EN to add cmd_start, loaded (clamped) on command accept.
module updown_count_sequencer
   import udseq_pkg::*;
#(
   parameter int MAX_VAL = DEF_MAX_VAL,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int STEP_W  = DEF_STEP_W
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
`ifdef UDSEQ_PRELOAD_EN
   input  logic [CNT_W-1:0]  cmd_start,
`endif
   output logic [CNT_W-1:0]  Count,
   output logic              busy,
   output logic              done,
   output logic              wrap
);
   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

   state_t            state_q, state_d;
   logic              dir_q, dir_d;
   logic [STEP_W-1:0] rem_q, rem_d;
   logic              wrap_q, wrap_d;
   logic              accept;
   logic              step_en;
   logic              load_en;
   logic [CNT_W-1:0]  load_val;
   logic              wrap_next;

   assign cmd_ready = (state_q == IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;

`ifdef UDSEQ_PRELOAD_EN
   assign load_en  = accept;
   assign load_val = cmd_start;
`else
   assign load_en  = 1'b0;
   assign load_val = '0;
`endif

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      rem_d   = rem_q;
      step_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               dir_d   = cmd_dir;
               rem_d   = cmd_steps;
               state_d = (cmd_steps == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            step_en = 1'b1;
            rem_d   = rem_q - STEP_ONE;
            if (rem_q == STEP_ONE) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Registered so wrap lines up with the wrapped Count value.
      wrap_d = step_en && wrap_next;
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         dir_q   <= DIR_UP;
         rem_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         rem_q   <= rem_d;
         wrap_q  <= wrap_d;
      end
   end

   updown_mod_counter #(
      .MAX_VAL (MAX_VAL),
      .CNT_W   (CNT_W)
   ) u_counter (
      .Clk       (Clk),
      .reset     (reset),
      .en        (step_en),
      .dir       (dir_q),
      .load      (load_en),
      .load_val  (load_val),
      .Count     (Count),
      .wrap_next (wrap_next)
   );

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign wrap = wrap_q;
endmodule

// File: tb/tb_updown_count_sequencer.sv
// Scoreboard bench: stimulus pushes per-busy-cycle expectations, monitor pops at negedge.
module tb_updown_count_sequencer;
   localparam int MAXV = 10;

   logic       Clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_dir = 1'b0;
   logic [7:0] cmd_steps = 8'd0;
   logic [3:0] cmd_start = 4'd0;
   logic [3:0] Count;
   logic       busy, done, wrap;

   updown_count_sequencer dut (
      .Clk       (Clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_steps (cmd_steps),
`ifdef UDSEQ_PRELOAD_EN
      .cmd_start (cmd_start),
`endif
      .Count     (Count),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int count;
      bit wrap;
      bit done;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   exp_idle = 0;
   int   model_count = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected completion at %0t", name, $time);
   endtask

   // Monitor: each busy cycle consumes one expectation; idle cycles must be quiet.
   initial begin
      forever begin
         @(negedge Clk);
         if (busy) begin
            if (sb.size() == 0) begin
               timeout_fail("unexpected_busy_cycle");
            end else begin
               mon_e = sb.pop_front();
               check("count", int'(Count), mon_e.count);
               check("wrap", int'(wrap), int'(mon_e.wrap));
               check("done", int'(done), int'(mon_e.done));
            end
         end else begin
            check("idle_count", int'(Count), exp_idle);
            check("idle_done", int'(done), 0);
            check("idle_wrap", int'(wrap), 0);
         end
      end
   end

   // Expected sequence: first busy cycle shows start value, then one step per cycle.
   task automatic push_cmd(input bit dir, input int steps, input int start);
      int c;
      bit w;
      c = start;
      sb.push_back('{count: c, wrap: 1'b0, done: (steps == 0)});
      for (int i = 1; i <= steps; i++) begin
         w = 1'b0;
         if (dir) begin
            if (c == MAXV) begin c = 0; w = 1'b1; end else c = c + 1;
         end else begin
            if (c == 0) begin c = MAXV; w = 1'b1; end else c = c - 1;
         end
         sb.push_back('{count: c, wrap: w, done: (i == steps)});
      end
      model_count = c;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge Clk); #2;
         n++;
      end
      if (!cmd_ready) timeout_fail("wait_ready");
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 1000) begin
         @(posedge Clk); #2;
         n++;
      end
      if (busy) timeout_fail("wait_idle");
   endtask

   task automatic do_cmd(input bit dir, input int steps, input int start, input bit use_start);
      int st;
      st = model_count;
      cmd_start = 4'(model_count);
`ifdef UDSEQ_PRELOAD_EN
      if (use_start) begin
         st = (start > MAXV) ? MAXV : start;
         cmd_start = 4'(start);
      end
`endif
      push_cmd(dir, steps, st);
      cmd_dir   = dir;
      cmd_steps = 8'(steps);
      cmd_valid = 1'b1;
      wait_ready();
      @(posedge Clk); #2;
      cmd_valid = 1'b0;
      cmd_dir   = ~dir;
      cmd_steps = 8'hff;
      wait_idle();
      exp_idle = model_count;
      check("scoreboard_drained", sb.size(), 0);
      $display("cmd dir=%0d steps=%0d start=%0d use_start=%0d -> count=%0d",
               dir, steps, cmd_start, use_start, Count);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b1;
      #1;
      check("rst_count", int'(Count), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_wrap", int'(wrap), 0);
      check("rst_ready", int'(cmd_ready), 0);
      @(posedge Clk); @(posedge Clk); #2;
      reset = 1'b0;
      #1 check("ready_after_rst", int'(cmd_ready), 1);

      do_cmd(1'b1, 3, 0, 1'b0);   // 1,2,3 no wrap
      do_cmd(1'b1, 8, 0, 1'b0);   // 3 -> 0 with one wrap
      do_cmd(1'b0, 2, 0, 1'b0);   // 0 -> 10 (wrap), 9
      do_cmd(1'b1, 12, 0, 1'b0);  // 9 -> 10,0..10, single wrap
      do_cmd(1'b0, 0, 0, 1'b0);   // zero steps: done only

      // Reset mid-run with a second command already waiting.
      push_cmd(1'b1, 5, model_count);
      cmd_start = 4'(exp_idle);
      cmd_dir   = 1'b1;
      cmd_steps = 8'd5;
      cmd_valid = 1'b1;
      wait_ready();
      @(posedge Clk); #2;
      cmd_dir   = 1'b0;
      cmd_steps = 8'd1;
      cmd_start = 4'd0;
      @(posedge Clk); #2;
      @(posedge Clk); #2;
      reset = 1'b1;
      #1;
      check("midrun_rst_count", int'(Count), 0);
      check("midrun_rst_busy", int'(busy), 0);
      check("midrun_rst_done", int'(done), 0);
      check("midrun_rst_ready", int'(cmd_ready), 0);
      sb.delete();
      exp_idle = 0;
      model_count = 0;
      @(posedge Clk); #2;
      reset = 1'b0;
      #1 check("ready_after_midrun_rst", int'(cmd_ready), 1);
      push_cmd(1'b0, 1, 0);
      @(posedge Clk); #2;
      cmd_valid = 1'b0;
      wait_idle();
      exp_idle = model_count;
      check("pending_drained", sb.size(), 0);
      check("pending_final_count", int'(Count), 10);
      $display("cmd pending dir=0 steps=1 after reset -> count=%0d", Count);

`ifdef UDSEQ_PRELOAD_EN
      do_cmd(1'b1, 1, 14, 1'b1); // clamp to 10 on load, then wrap to 0
      check("preload_final_count", int'(Count), 0);
`endif

      @(posedge Clk); #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
